ucsbece154b_mem_arbiter: RTL and testbench

UCSBECE154B_MEM_ARBITER -- requirements
Module: ucsbece154b_mem_arbiter

---
 rtl/ucsbece154b_mem_arbiter.sv | 73 +++++++
 tb/tb_ucsbece154b_mem_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_mem_arbiter.sv
// ucsbece154b_mem_arbiter: shares one SDRAM burst-read port between the icache and the prefetcher,
// with icache priority bounded by a starvation counter.
module ucsbece154b_mem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_data,
  output logic        ic_ready,
  output logic        ic_done,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  output logic [31:0] pf_data,
  output logic        pf_ready,
  output logic        pf_done,
  output logic        MemReadRequest,
  output logic [31:0] MemReadAddress,
  input  logic [31:0] MemDataIn,
  input  logic        MemDataReady,
  output logic        busy
);
  localparam int WW = $clog2(BLOCK_WORDS);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(BLOCK_WORDS - 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [31:0] OFFSET_MASK = 32'(BLOCK_WORDS * 4 - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;
  state_t state, stateNext;
  logic owner;
  logic [WW-1:0] wordCnt;
  logic [SW-1:0] starveCnt;
  logic grantPf, grantIc, beat, lastBeat;
  // owner: 0 = icache, 1 = prefetcher
  always_comb begin
    grantPf = pf_req & (~ic_req | (starveCnt == LIMIT));
    grantIc = ic_req & ~grantPf;
    beat = (state == BURST) & MemDataReady;
    lastBeat = beat & (wordCnt == LAST_WORD);
    stateNext = state;
    stateNext = state == IDLE ? ((grantIc | grantPf) ? ISSUE : IDLE) :
                state == ISSUE ? BURST :
                lastBeat ? IDLE : BURST;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      wordCnt <= '0;
      starveCnt <= '0;
      MemReadAddress <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && (grantIc | grantPf)) begin
        owner <= grantPf;
        MemReadAddress <= (grantPf ? pf_addr : ic_addr) & ~OFFSET_MASK;
      end
      if (beat) wordCnt <= lastBeat ? '0 : wordCnt + WW'(1);
      if (state == IDLE)
        starveCnt <= (grantPf | ~pf_req) ? '0 :
                     (grantIc && starveCnt != LIMIT) ? starveCnt + SW'(1) : starveCnt;
    end
  assign MemReadRequest = state == ISSUE;
  assign busy = state != IDLE;
  assign ic_data = MemDataIn;
  assign pf_data = MemDataIn;
  assign ic_ready = beat & ~owner;
  assign pf_ready = beat & owner;
  assign ic_done = lastBeat & ~owner;
  assign pf_done = lastBeat & owner;
endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// tb_ucsbece154b_mem_arbiter: scoreboard bench for the icache/prefetch SDRAM arbiter.
module tb_ucsbece154b_mem_arbiter;
  localparam int BW = 4;
  logic clk, reset;
  logic ic_req, pf_req, ic_ready, ic_done, pf_ready, pf_done;
  logic [31:0] ic_addr, pf_addr, ic_data, pf_data;
  logic MemReadRequest, MemDataReady, busy;
  logic [31:0] MemReadAddress, MemDataIn;
  logic [31:0] addrQ[$];
  logic [63:0] dataQ[$];
  int checks = 0;
  int errors = 0;

  ucsbece154b_mem_arbiter #(.BLOCK_WORDS(BW), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_data(ic_data), .ic_ready(ic_ready), .ic_done(ic_done),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_data(pf_data), .pf_ready(pf_ready), .pf_done(pf_done),
    .MemReadRequest(MemReadRequest), .MemReadAddress(MemReadAddress),
    .MemDataIn(MemDataIn), .MemDataReady(MemDataReady), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // monitor samples mid-cycle, between the negedge drive and the next posedge
  always @(negedge clk) begin
    #2;
    if (MemReadRequest) begin
      if (addrQ.size() == 0) chk("unexp_req", 1, 0);
      else chk("addr", MemReadAddress, addrQ.pop_front());
    end
    if (ic_ready & pf_ready) chk("dual_ready", 1, 0);
    if ((ic_done & ~ic_ready) | (pf_done & ~pf_ready)) chk("orphan_done", 1, 0);
    if (ic_ready | pf_ready) begin
      if (dataQ.size() == 0) chk("unexp_ready", 1, 0);
      else chk("word", {30'b0, pf_ready, pf_ready ? pf_done : ic_done, pf_ready ? pf_data : ic_data},
               dataQ.pop_front());
    end
  end

  task automatic waitIssue(input logic [31:0] addr, input bit pf);
    int n = 0;
    addrQ.push_back(addr);
    do begin
      @(negedge clk);
      MemDataReady = 1'b0;
      #1;
      n++;
    end while (!MemReadRequest && n < 20);
    if (!MemReadRequest) chk("issue_timeout", 0, 1);
    chk("busy_issue", busy, 1);
    if (pf) pf_addr = $urandom; else ic_addr = $urandom;
  endtask

  task automatic driveWord(input bit pf, input bit last);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      MemDataReady = 1'b0;
      MemDataIn = $urandom;
    end
    @(negedge clk);
    MemDataReady = 1'b1;
    MemDataIn = $urandom;
    dataQ.push_back({30'b0, pf, last, MemDataIn});
  endtask

  task automatic serveBurst(input bit pf, input logic [31:0] addr, input bit drop,
                            input int raiseAt, input logic [31:0] raiseAddr);
    waitIssue(addr, pf);
    for (int w = 0; w < BW; w++) begin
      driveWord(pf, w == BW - 1);
      if (w == raiseAt) begin
        ic_req = 1'b1;
        ic_addr = raiseAddr;
      end
      if (w == BW - 1 && drop) begin
        if (pf) pf_req = 1'b0; else ic_req = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; ic_req = 1'b0; pf_req = 1'b0; ic_addr = '0; pf_addr = '0;
    MemDataIn = 32'hDEAD_BEEF; MemDataReady = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("reset_outs", {MemReadRequest, MemReadAddress, busy, ic_ready, ic_done, pf_ready, pf_done}, 0);
    @(negedge clk);
    reset = 1'b0; MemDataReady = 1'b0;
    // stray data with no requests
    repeat (3) begin
      @(negedge clk);
      MemDataReady = 1'b1;
      MemDataIn = $urandom;
      #1 chk("idle_busy", busy, 0);
    end
    @(negedge clk);
    MemDataReady = 1'b0; ic_addr = 32'h0000_0104; ic_req = 1'b1;
    serveBurst(0, 32'h0000_0100, 1, -1, 0);
    // simultaneous requests: icache first, then prefetcher
    @(negedge clk);
    MemDataReady = 1'b0; ic_addr = 32'h0000_034C; pf_addr = 32'h0000_0200; ic_req = 1'b1; pf_req = 1'b1;
    serveBurst(0, 32'h0000_0340, 1, -1, 0);
    serveBurst(1, 32'h0000_0200, 1, -1, 0);
    repeat (2) @(negedge clk);
    // starvation: eight icache bursts, then the prefetcher, then icache again
    MemDataReady = 1'b0; ic_addr = 32'h0000_1008; pf_addr = 32'h0000_2000; ic_req = 1'b1; pf_req = 1'b1;
    for (int k = 0; k < 8; k++) serveBurst(0, ic_addr & 32'hFFFF_FFF0, 0, -1, 0);
    serveBurst(1, 32'h0000_2000, 1, -1, 0);
    serveBurst(0, ic_addr & 32'hFFFF_FFF0, 1, -1, 0);
    repeat (2) @(negedge clk);
    // icache miss raised during a prefetch burst waits for it to finish
    MemDataReady = 1'b0; pf_addr = 32'h0000_4444; pf_req = 1'b1;
    serveBurst(1, 32'h0000_4440, 1, 1, 32'h0000_5558);
    serveBurst(0, 32'h0000_5550, 1, -1, 0);
    repeat (2) @(negedge clk);
    // reset in the middle of a burst
    MemDataReady = 1'b0; ic_addr = 32'h1234_5678; ic_req = 1'b1;
    waitIssue(32'h1234_5670, 0);
    driveWord(0, 0);
    driveWord(0, 0);
    @(negedge clk);
    reset = 1'b1; MemDataReady = 1'b0; ic_req = 1'b0;
    #1 chk("rst_busy", busy, 0);
    chk("rst_addr", MemReadAddress, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      MemDataReady = 1'b1;
      MemDataIn = $urandom;
      #1 chk("post_rst_busy", busy, 0);
    end
    @(negedge clk);
    MemDataReady = 1'b0; ic_addr = 32'h0000_0080; ic_req = 1'b1;
    serveBurst(0, 32'h0000_0080, 1, -1, 0);
    repeat (3) @(negedge clk);
    MemDataReady = 1'b0;
    #3 chk("data_left", dataQ.size(), 0);
    chk("addr_left", addrQ.size(), 0);
    chk("end_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
